iob_axi_burst_responder: RTL and testbench

IOB_AXI_BURST_RESPONDER -- requirements
Module: iob_axi_burst_responder

---
 rtl/iob_axi_burst_responder.sv | 196 +++++++++++++++++++
 tb/tb_iob_axi_burst_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_axi_burst_responder.sv
// rtl/iob_axi_burst_responder.sv - AXI burst slave backed by an internal byte-enabled word memory
module iob_axi_burst_responder #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 8,
    parameter int ID_W       = 1,
    parameter int MEM_ADDR_W = 10
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic [ID_W-1:0]     axi_awid_i,
    input  logic [ADDR_W-1:0]   axi_awaddr_i,
    input  logic [LEN_W-1:0]    axi_awlen_i,
    input  logic                axi_awvalid_i,
    output logic                axi_awready_o,
    input  logic [DATA_W-1:0]   axi_wdata_i,
    input  logic [DATA_W/8-1:0] axi_wstrb_i,
    input  logic                axi_wlast_i,
    input  logic                axi_wvalid_i,
    output logic                axi_wready_o,
    output logic [ID_W-1:0]     axi_bid_o,
    output logic [1:0]          axi_bresp_o,
    output logic                axi_bvalid_o,
    input  logic                axi_bready_i,
    input  logic [ID_W-1:0]     axi_arid_i,
    input  logic [ADDR_W-1:0]   axi_araddr_i,
    input  logic [LEN_W-1:0]    axi_arlen_i,
    input  logic                axi_arvalid_i,
    output logic                axi_arready_o,
    output logic [ID_W-1:0]     axi_rid_o,
    output logic [DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]          axi_rresp_o,
    output logic                axi_rlast_o,
    output logic                axi_rvalid_o,
    input  logic                axi_rready_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int DEPTH  = 2 ** MEM_ADDR_W;
    localparam logic [MEM_ADDR_W-1:0] IDX_ONE = 1;
    localparam logic [LEN_W-1:0]      LEN_ONE = 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    w_state_t              w_state, w_next;
    logic [ID_W-1:0]       w_id;
    logic [MEM_ADDR_W-1:0] w_idx;
    logic [LEN_W-1:0]      w_cnt;
    logic [1:0]            w_resp;
    logic                  aw_fire, w_fire, w_end, b_fire;

    r_state_t              r_state, r_next;
    logic [ID_W-1:0]       r_id;
    logic [MEM_ADDR_W-1:0] r_idx;
    logic [LEN_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_data;
    logic                  r_last;
    logic                  ar_fire, r_fire, r_load;

    // Only the word-index bits of the addresses matter; the rest are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{axi_awaddr_i, axi_araddr_i};

    assign aw_fire = axi_awvalid_i && axi_awready_o;
    assign w_fire  = axi_wvalid_i && axi_wready_o;
    assign b_fire  = axi_bvalid_o && axi_bready_i;
    assign w_end   = axi_wlast_i || (w_cnt == '0);

    assign ar_fire = axi_arvalid_i && axi_arready_o;
    assign r_fire  = axi_rvalid_o && axi_rready_i;
    // The output register is refilled on the fetch cycle and on every non-final beat handshake.
    assign r_load  = (r_state == R_FETCH) || (r_fire && !r_last);

    // Write FSM state register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    // Write FSM next state and channel handshake outputs.
    always_comb begin
        w_next        = w_state;
        axi_awready_o = 1'b0;
        axi_wready_o  = 1'b0;
        axi_bvalid_o  = 1'b0;
        case (w_state)
            W_IDLE: begin
                axi_awready_o = 1'b1;
                if (aw_fire) w_next = W_DATA;
            end
            W_DATA: begin
                axi_wready_o = 1'b1;
                if (w_fire && w_end) w_next = W_RESP;
            end
            W_RESP: begin
                axi_bvalid_o = 1'b1;
                if (b_fire) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write burst context: ID, running word index, remaining beats and the response code.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            w_id   <= '0;
            w_idx  <= '0;
            w_cnt  <= '0;
            w_resp <= RESP_OKAY;
        end else if (aw_fire) begin
            w_id  <= axi_awid_i;
            w_idx <= axi_awaddr_i[MEM_ADDR_W+OFF_W-1:OFF_W];
            w_cnt <= axi_awlen_i;
        end else if (w_fire) begin
            w_idx <= w_idx + IDX_ONE;
            w_cnt <= w_cnt - LEN_ONE;
            if (w_end)
                w_resp <= (axi_wlast_i && (w_cnt == '0)) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Byte-enabled memory write; contents survive reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < STRB_W; b++) begin
            if (w_fire && axi_wstrb_i[b])
                mem[w_idx][b*8 +: 8] <= axi_wdata_i[b*8 +: 8];
        end
    end

    assign axi_bid_o   = w_id;
    assign axi_bresp_o = w_resp;

    // Read FSM state register.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    // Read FSM next state and channel handshake outputs.
    always_comb begin
        r_next        = r_state;
        axi_arready_o = 1'b0;
        axi_rvalid_o  = 1'b0;
        case (r_state)
            R_IDLE: begin
                axi_arready_o = 1'b1;
                if (ar_fire) r_next = R_FETCH;
            end
            R_FETCH: r_next = R_DATA;
            R_DATA: begin
                axi_rvalid_o = 1'b1;
                if (r_fire && r_last) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read datapath: registered memory read into the beat register, held while stalled.
    // r_cnt counts beats still to be loaded after the one currently presented.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_id   <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_last <= 1'b0;
        end else if (ar_fire) begin
            r_id  <= axi_arid_i;
            r_idx <= axi_araddr_i[MEM_ADDR_W+OFF_W-1:OFF_W];
            r_cnt <= axi_arlen_i;
        end else if (r_load) begin
            r_data <= mem[r_idx];
            r_idx  <= r_idx + IDX_ONE;
            if (r_state == R_FETCH) begin
                r_last <= (r_cnt == '0);
            end else begin
                r_last <= (r_cnt == LEN_ONE);
                r_cnt  <= r_cnt - LEN_ONE;
            end
        end else if (r_fire) begin
            r_last <= 1'b0;
        end
    end

    assign axi_rid_o   = r_id;
    assign axi_rdata_o = r_data;
    assign axi_rlast_o = r_last;
    assign axi_rresp_o = RESP_OKAY;

endmodule

// File: tb/tb_iob_axi_burst_responder.sv
// tb/tb_iob_axi_burst_responder.sv - randomized self-checking bench with a word-array memory model
module tb_iob_axi_burst_responder;

    logic        clk_i = 1'b0;
    logic        arst_i = 1'b1;
    logic [0:0]  axi_awid_i = '0;
    logic [23:0] axi_awaddr_i = '0;
    logic [7:0]  axi_awlen_i = '0;
    logic        axi_awvalid_i = 1'b0;
    logic        axi_awready_o;
    logic [31:0] axi_wdata_i = '0;
    logic [3:0]  axi_wstrb_i = '0;
    logic        axi_wlast_i = 1'b0;
    logic        axi_wvalid_i = 1'b0;
    logic        axi_wready_o;
    logic [0:0]  axi_bid_o;
    logic [1:0]  axi_bresp_o;
    logic        axi_bvalid_o;
    logic        axi_bready_i = 1'b0;
    logic [0:0]  axi_arid_i = '0;
    logic [23:0] axi_araddr_i = '0;
    logic [7:0]  axi_arlen_i = '0;
    logic        axi_arvalid_i = 1'b0;
    logic        axi_arready_o;
    logic [0:0]  axi_rid_o;
    logic [31:0] axi_rdata_o;
    logic [1:0]  axi_rresp_o;
    logic        axi_rlast_o;
    logic        axi_rvalid_o;
    logic        axi_rready_i = 1'b0;

    int total = 0;
    int bad = 0;

    logic [31:0] mdl  [0:1023];
    logic [31:0] wbuf [0:255];
    logic [31:0] rbuf [0:255];

    iob_axi_burst_responder dut (
        .clk_i(clk_i), .arst_i(arst_i),
        .axi_awid_i(axi_awid_i), .axi_awaddr_i(axi_awaddr_i), .axi_awlen_i(axi_awlen_i),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o),
        .axi_wdata_i(axi_wdata_i), .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o),
        .axi_bid_o(axi_bid_o), .axi_bresp_o(axi_bresp_o), .axi_bvalid_o(axi_bvalid_o),
        .axi_bready_i(axi_bready_i),
        .axi_arid_i(axi_arid_i), .axi_araddr_i(axi_araddr_i), .axi_arlen_i(axi_arlen_i),
        .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
        .axi_rid_o(axi_rid_o), .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o),
        .axi_rlast_o(axi_rlast_o), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i)
    );

    always #5 clk_i = ~clk_i;

    // Sends one write burst of min(len,last_at)+1 beats from wbuf and checks the response.
    task automatic do_write(input logic [0:0] id, input logic [23:0] addr, input int len,
                            input int last_at, input logic [3:0] strb);
        int nb, t, idx;
        logic [1:0] eresp;
        nb    = ((last_at < len) ? last_at : len) + 1;
        eresp = (last_at == len) ? 2'b00 : 2'b10;
        idx   = int'(addr[11:2]);
        axi_awid_i = id; axi_awaddr_i = addr; axi_awlen_i = len[7:0]; axi_awvalid_i = 1'b1;
        t = 0;
        while (!axi_awready_o && t < 200) begin @(negedge clk_i); t++; end
        total++;
        if (axi_awready_o !== 1'b1) begin bad++; $display("FAIL aw_timeout got=%b exp=1", axi_awready_o); end
        @(posedge clk_i); @(negedge clk_i);
        axi_awvalid_i = 1'b0;
        for (int i = 0; i < nb; i++) begin
            axi_wdata_i = wbuf[i]; axi_wstrb_i = strb; axi_wlast_i = (i == last_at); axi_wvalid_i = 1'b1;
            t = 0;
            while (!axi_wready_o && t < 200) begin @(negedge clk_i); t++; end
            total++;
            if (axi_wready_o !== 1'b1) begin bad++; $display("FAIL w_timeout beat=%0d got=%b exp=1", i, axi_wready_o); end
            @(posedge clk_i);
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[idx][b*8 +: 8] = wbuf[i][b*8 +: 8];
            idx = (idx + 1) % 1024;
            @(negedge clk_i);
        end
        axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0;
        total++;
        if (axi_wready_o !== 1'b0) begin bad++; $display("FAIL wready_after_last got=%b exp=0", axi_wready_o); end
        total++;
        if (axi_bvalid_o !== 1'b1) begin bad++; $display("FAIL bvalid got=%b exp=1", axi_bvalid_o); end
        total++;
        if (axi_bresp_o !== eresp) begin bad++; $display("FAIL bresp got=%b exp=%b", axi_bresp_o, eresp); end
        total++;
        if (axi_bid_o !== id) begin bad++; $display("FAIL bid got=%b exp=%b", axi_bid_o, id); end
        axi_bready_i = 1'b1;
        @(posedge clk_i); @(negedge clk_i);
        axi_bready_i = 1'b0;
        total++;
        if (axi_bvalid_o !== 1'b0 || axi_awready_o !== 1'b1)
            begin bad++; $display("FAIL b_done got bvalid=%b awready=%b exp bvalid=0 awready=1", axi_bvalid_o, axi_awready_o); end
    endtask

    // Reads a burst; mode 0 = rready always high, 1 = pattern 1,0,0,1, 2 = random.
    task automatic do_read(input logic [0:0] id, input logic [23:0] addr, input int len, input int mode);
        int t, beats, cyc, idx;
        logic stall, rr, hold_l;
        logic [31:0] hold_d;
        idx = int'(addr[11:2]);
        axi_arid_i = id; axi_araddr_i = addr; axi_arlen_i = len[7:0]; axi_arvalid_i = 1'b1;
        t = 0;
        while (!axi_arready_o && t < 200) begin @(negedge clk_i); t++; end
        total++;
        if (axi_arready_o !== 1'b1) begin bad++; $display("FAIL ar_timeout got=%b exp=1", axi_arready_o); end
        @(posedge clk_i); @(negedge clk_i);
        axi_arvalid_i = 1'b0;
        total++;
        if (axi_rvalid_o !== 1'b0) begin bad++; $display("FAIL rvalid_early got=%b exp=0", axi_rvalid_o); end
        @(negedge clk_i);
        total++;
        if (axi_rvalid_o !== 1'b1) begin bad++; $display("FAIL rvalid_first got=%b exp=1", axi_rvalid_o); end
        beats = 0; cyc = 0; stall = 1'b0; hold_d = '0; hold_l = 1'b0;
        while (beats <= len && cyc < 4000) begin
            case (mode)
                0:       rr = 1'b1;
                1:       rr = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            axi_rready_i = rr;
            if (axi_rvalid_o) begin
                if (stall) begin
                    total++;
                    if (axi_rdata_o !== hold_d || axi_rlast_o !== hold_l)
                        begin bad++; $display("FAIL r_stable got=%h/%b exp=%h/%b", axi_rdata_o, axi_rlast_o, hold_d, hold_l); end
                end
                if (rr) begin
                    total++;
                    if (axi_rdata_o !== mdl[(idx + beats) % 1024])
                        begin bad++; $display("FAIL rdata beat=%0d got=%h exp=%h", beats, axi_rdata_o, mdl[(idx + beats) % 1024]); end
                    total++;
                    if (axi_rlast_o !== (beats == len))
                        begin bad++; $display("FAIL rlast beat=%0d got=%b exp=%b", beats, axi_rlast_o, (beats == len)); end
                    total++;
                    if (axi_rid_o !== id || axi_rresp_o !== 2'b00)
                        begin bad++; $display("FAIL rid_rresp got=%b/%b exp=%b/00", axi_rid_o, axi_rresp_o, id); end
                    rbuf[beats] = axi_rdata_o;
                    beats++;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1; hold_d = axi_rdata_o; hold_l = axi_rlast_o;
                end
            end
            @(posedge clk_i); @(negedge clk_i);
            cyc++;
        end
        axi_rready_i = 1'b0;
        total++;
        if (beats != len + 1) begin bad++; $display("FAIL r_beats got=%0d exp=%0d", beats, len + 1); end
        total++;
        if (axi_rvalid_o !== 1'b0 || axi_arready_o !== 1'b1)
            begin bad++; $display("FAIL r_done got rvalid=%b arready=%b exp 0/1", axi_rvalid_o, axi_arready_o); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        total++;
        if ({axi_awready_o, axi_arready_o, axi_wready_o, axi_bvalid_o, axi_rvalid_o, axi_rlast_o} !== 6'b110000)
            begin bad++; $display("FAIL reset_ctrl got=%b exp=110000",
                {axi_awready_o, axi_arready_o, axi_wready_o, axi_bvalid_o, axi_rvalid_o, axi_rlast_o}); end
        total++;
        if ({axi_bresp_o, axi_bid_o, axi_rid_o, axi_rdata_o} !== 36'h0)
            begin bad++; $display("FAIL reset_data got=%h exp=0", {axi_bresp_o, axi_bid_o, axi_rid_o, axi_rdata_o}); end
        arst_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_fill();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) wbuf[i] = $urandom;
            do_write(1'b0, 24'(k * 1024), 255, 255, 4'hF);
        end
    endtask

    task automatic test_basic();
        logic [31:0] e;
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
        do_write(1'b1, 24'h000010, 3, 3, 4'hF);
        do_read(1'b1, 24'h000010, 3, 0);
        for (int i = 0; i < 4; i++) begin
            e = 32'hA0 + 32'(i);
            total++;
            if (rbuf[i] !== e) begin bad++; $display("FAIL basic_data beat=%0d got=%h exp=%h", i, rbuf[i], e); end
        end
    endtask

    task automatic test_backpressure();
        do_read(1'b0, 24'h000010, 3, 1);
        do_read(1'b1, 24'h000300, 9, 1);
    endtask

    task automatic test_strobe();
        wbuf[0] = 32'h12345678;
        do_write(1'b0, 24'h000040, 0, 0, 4'hF);
        wbuf[0] = 32'hFFFFFFFF;
        do_write(1'b0, 24'h000040, 0, 0, 4'h3);
        do_read(1'b0, 24'h000040, 0, 0);
        total++;
        if (rbuf[0] !== 32'h1234FFFF) begin bad++; $display("FAIL strobe got=%h exp=1234ffff", rbuf[0]); end
    endtask

    task automatic test_bad_last();
        wbuf[0] = 32'h5A5A0001; wbuf[1] = 32'h5A5A0002;
        do_write(1'b1, 24'h000080, 1, 0, 4'hF);
        do_write(1'b0, 24'h000090, 0, 1, 4'hF);
        do_read(1'b0, 24'h000080, 5, 0);
    endtask

    task automatic test_wrap();
        wbuf[0] = 32'hC0C0C0C0; wbuf[1] = 32'hC1C1C1C1;
        do_write(1'b0, 24'h000FFC, 1, 1, 4'hF);
        do_read(1'b0, 24'h000000, 0, 0);
        total++;
        if (rbuf[0] !== 32'hC1C1C1C1) begin bad++; $display("FAIL wrap_word0 got=%h exp=c1c1c1c1", rbuf[0]); end
        do_read(1'b1, 24'h000FFC, 1, 2);
    endtask

    task automatic test_concurrent();
        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        fork
            do_write(1'b1, 24'h000200, 7, 7, 4'hF);
            do_read(1'b0, 24'h000800, 7, 2);
        join
        do_read(1'b1, 24'h000200, 7, 0);
    endtask

    task automatic test_reset_mid_read();
        int t;
        axi_arid_i = 1'b1; axi_araddr_i = 24'h000100; axi_arlen_i = 8'd7; axi_arvalid_i = 1'b1;
        t = 0;
        while (!axi_arready_o && t < 200) begin @(negedge clk_i); t++; end
        @(posedge clk_i); @(negedge clk_i);
        axi_arvalid_i = 1'b0; axi_rready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        total++;
        if (axi_rvalid_o !== 1'b1) begin bad++; $display("FAIL midread_active got=%b exp=1", axi_rvalid_o); end
        arst_i = 1'b1;
        #1;
        total++;
        if (axi_rvalid_o !== 1'b0 || axi_arready_o !== 1'b1 || axi_rlast_o !== 1'b0 || axi_rdata_o !== 32'h0)
            begin bad++; $display("FAIL midread_reset got rvalid=%b arready=%b rlast=%b rdata=%h exp 0/1/0/0",
                axi_rvalid_o, axi_arready_o, axi_rlast_o, axi_rdata_o); end
        @(negedge clk_i);
        arst_i = 1'b0; axi_rready_i = 1'b0;
        @(negedge clk_i);
        do_read(1'b0, 24'h000100, 3, 0);
    endtask

    task automatic test_random();
        logic [23:0] a;
        int len;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            a = 24'($urandom);
            len = $urandom_range(0, 15);
            do_write(1'($urandom), a, len, len, 4'($urandom));
            a = 24'($urandom);
            do_read(1'($urandom), a, $urandom_range(0, 15), 2);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_backpressure();
        test_strobe();
        test_bad_last();
        test_wrap();
        test_concurrent();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
